// File: rtl/dmem_bytewr.sv
// Single-clock data memory with per-byte write enables and a valid/ready request port.
// Optional DMEM_BOUNDS_EN: out-of-range addresses answer with resp_err instead of aliasing.
module dmem_bytewr #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 15,
    parameter int DEPTH      = 2048
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_we,
    input  logic [ADDR_WIDTH-1:0]      req_addr,
    input  logic [DATA_WIDTH-1:0]      req_wdata,
    input  logic [DATA_WIDTH/8-1:0]    req_byteena,
    output logic                       resp_valid,
    output logic [DATA_WIDTH-1:0]      resp_rdata,
    output logic                       resp_err
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [0:0] {IDLE, MERGE} state_t;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic [IDX_W-1:0]        addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [BE_WIDTH-1:0]     be_q;
    logic [DATA_WIDTH-1:0]   old_q;
    logic [DATA_WIDTH-1:0]   merged;

    logic                    accept;
    logic                    be_full;
    logic                    be_zero;
    logic                    oob;
    logic                    do_full_wr;
    logic                    do_partial;
    logic [IDX_W-1:0]        idx;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;
    assign be_full   = &req_byteena;
    assign be_zero   = ~|req_byteena;
    assign idx       = req_addr[IDX_W-1:0];

`ifdef DMEM_BOUNDS_EN
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
    assign oob = ({1'b0, req_addr} >= DEPTH_L);
`else
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr;
    assign oob = 1'b0;
`endif

    assign do_full_wr = accept && req_we && be_full && !oob;
    assign do_partial = accept && req_we && !be_full && !be_zero && !oob;

    always_comb begin
        merged = old_q;
        for (int unsigned i = 0; i < BE_WIDTH; i++) begin
            if (be_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
        end
    end

    // Storage and RMW latches carry no reset; resetn only blocks writes so an
    // interrupted merge leaves the old word in place.
    always_ff @(posedge clock) begin
        if (resetn) begin
            if (state == MERGE) begin
                mem[addr_q] <= merged;
            end else if (do_full_wr) begin
                mem[idx] <= req_wdata;
            end
            if (do_partial) begin
                addr_q  <= idx;
                wdata_q <= req_wdata;
                be_q    <= req_byteena;
                old_q   <= mem[idx];
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (do_partial) begin
                            state <= MERGE;
                        end else begin
                            resp_valid <= 1'b1;
                            resp_err   <= oob;
                            resp_rdata <= oob ? '0 : mem[idx];
                        end
                    end
                end
                MERGE: begin
                    state      <= IDLE;
                    resp_valid <= 1'b1;
                    resp_rdata <= old_q;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_bytewr.sv
// Directed-vector bench for dmem_bytewr; bounds vectors follow DMEM_BOUNDS_EN.
module tb_dmem_bytewr;

    logic        clock = 1'b0;
    logic        resetn;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [14:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_byteena;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int vectors     = 0;
    int miscompares = 0;

    dmem_bytewr #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (15),
        .DEPTH      (2048)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_byteena (req_byteena),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic we, input logic [14:0] a,
                         input logic [31:0] d, input logic [3:0] be);
        req_valid   = v;
        req_we      = we;
        req_addr    = a;
        req_wdata   = d;
        req_byteena = be;
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    initial begin
        resetn = 1'b0;
        drive(1'b0, 1'b0, 15'd0, 32'h0, 4'h0);
        tick;
        tick;
        check("rst_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_rdata", resp_rdata, 32'h0);
        check("rst_err", {31'b0, resp_err}, 32'd0);
        resetn = 1'b1;
        tick;
        check("rst_ready", {31'b0, req_ready}, 32'd1);
        check("idle_valid", {31'b0, resp_valid}, 32'd0);

        // full write then read of addr 5
        drive(1'b1, 1'b1, 15'd5, 32'hDEADBEEF, 4'hF);
        tick;
        check("fw_valid", {31'b0, resp_valid}, 32'd1);
        check("fw_ready", {31'b0, req_ready}, 32'd1);
        drive(1'b1, 1'b0, 15'd5, 32'h0, 4'h0);
        tick;
        check("rd5_valid", {31'b0, resp_valid}, 32'd1);
        check("rd5_rdata", resp_rdata, 32'hDEADBEEF);
        check("rd5_ready", {31'b0, req_ready}, 32'd1);

        // partial write be=0101; read held on the port through the merge
        drive(1'b1, 1'b1, 15'd5, 32'h11223344, 4'b0101);
        tick;
        check("pw_ready_low", {31'b0, req_ready}, 32'd0);
        check("pw_no_resp", {31'b0, resp_valid}, 32'd0);
        drive(1'b1, 1'b0, 15'd5, 32'h0, 4'h0);
        tick;
        check("pw_valid", {31'b0, resp_valid}, 32'd1);
        check("pw_old", resp_rdata, 32'hDEADBEEF);
        check("pw_ready_back", {31'b0, req_ready}, 32'd1);
        tick;
        check("pw_rd_valid", {31'b0, resp_valid}, 32'd1);
        check("pw_merged", resp_rdata, 32'hDE22BE44);

        // zero-byteena write behaves like a read
        drive(1'b1, 1'b1, 15'd5, 32'hFFFFFFFF, 4'h0);
        tick;
        check("zb_valid", {31'b0, resp_valid}, 32'd1);
        check("zb_rdata", resp_rdata, 32'hDE22BE44);
        check("zb_ready", {31'b0, req_ready}, 32'd1);
        drive(1'b1, 1'b0, 15'd5, 32'h0, 4'h0);
        tick;
        check("zb_reread", resp_rdata, 32'hDE22BE44);

        // reset during MERGE discards the pending write
        drive(1'b1, 1'b1, 15'd5, 32'hAABBCCDD, 4'b1000);
        tick;
        check("rm_ready_low", {31'b0, req_ready}, 32'd0);
        resetn = 1'b0;
        drive(1'b0, 1'b0, 15'd0, 32'h0, 4'h0);
        #2;
        check("rm_ready_async", {31'b0, req_ready}, 32'd1);
        check("rm_no_resp0", {31'b0, resp_valid}, 32'd0);
        tick;
        check("rm_no_resp1", {31'b0, resp_valid}, 32'd0);
        resetn = 1'b1;
        tick;
        check("rm_no_resp2", {31'b0, resp_valid}, 32'd0);
        check("rm_ready", {31'b0, req_ready}, 32'd1);
        drive(1'b1, 1'b0, 15'd5, 32'h0, 4'h0);
        tick;
        check("rm_valid", {31'b0, resp_valid}, 32'd1);
        check("rm_kept", resp_rdata, 32'hDE22BE44);

        // back-to-back full writes 0..7 (addr 5 returns its previous word)
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 15'(i), 32'h1000_0000 + 32'(i), 4'hF);
            tick;
            check("bw_valid", {31'b0, resp_valid}, 32'd1);
            if (i == 5) check("bw_old5", resp_rdata, 32'hDE22BE44);
        end

        // back-to-back reads 0..7 with req_valid held high
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 15'(i), 32'h0, 4'h0);
            tick;
            check("br_valid", {31'b0, resp_valid}, 32'd1);
            check("br_rdata", resp_rdata, 32'h1000_0000 + 32'(i));
            check("br_ready", {31'b0, req_ready}, 32'd1);
        end
        drive(1'b0, 1'b0, 15'd0, 32'h0, 4'h0);
        tick;
        check("br_pulse_end", {31'b0, resp_valid}, 32'd0);

`ifdef DMEM_BOUNDS_EN
        drive(1'b1, 1'b1, 15'd2048, 32'h12345678, 4'b0011);
        tick;
        check("oob_valid", {31'b0, resp_valid}, 32'd1);
        check("oob_err", {31'b0, resp_err}, 32'd1);
        check("oob_rdata", resp_rdata, 32'h0);
        check("oob_ready", {31'b0, req_ready}, 32'd1);
        drive(1'b1, 1'b0, 15'd0, 32'h0, 4'h0);
        tick;
        check("oob_rd0", resp_rdata, 32'h1000_0000);
        check("oob_rd0_err", {31'b0, resp_err}, 32'd0);
`else
        drive(1'b1, 1'b1, 15'd2048, 32'hCAFEF00D, 4'hF);
        tick;
        check("alias_valid", {31'b0, resp_valid}, 32'd1);
        check("alias_err", {31'b0, resp_err}, 32'd0);
        check("alias_old", resp_rdata, 32'h1000_0000);
        drive(1'b1, 1'b0, 15'd0, 32'h0, 4'h0);
        tick;
        check("alias_rd0", resp_rdata, 32'hCAFEF00D);
`endif
        drive(1'b0, 1'b0, 15'd0, 32'h0, 4'h0);
        tick;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
